// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - execute stage with ALU, iterative multiply/divide and EX/MEM register
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid, in_flush   instruction present / kill instruction in EX
//   in_read_data_1/2     operand A / operand B register (also store data)
//   in_sign_ext_imm      immediate, selected as B when in_alu_src = 1
//   in_alu_op, in_shamt  operation code and shift amount
//   in_mem_*, in_write_back, in_mem_to_reg, in_branch, in_load_mode, in_dest_reg
//                        control passthrough to the memory stage
//   stall                combinational, upstream holds while high
//   out_*                registered EX/MEM outputs
module ex_muldiv_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_flush,
    input  logic [DATA_W-1:0]     in_read_data_1,
    input  logic [DATA_W-1:0]     in_read_data_2,
    input  logic [DATA_W-1:0]     in_sign_ext_imm,
    input  logic                  in_alu_src,
    input  logic [3:0]            in_alu_op,
    input  logic [4:0]            in_shamt,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_write_back,
    input  logic                  in_mem_to_reg,
    input  logic                  in_branch,
    input  logic [1:0]            in_load_mode,
    input  logic [REG_ADDR_W-1:0] in_dest_reg,
    output logic                  stall,
    output logic [DATA_W-1:0]     out_address,
    output logic [DATA_W-1:0]     out_write_data,
    output logic                  out_zero,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_write_back,
    output logic                  out_mem_to_reg,
    output logic                  out_branch,
    output logic [1:0]            out_load_mode,
    output logic [REG_ADDR_W-1:0] out_dest_reg,
    output logic                  out_valid
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   hi, lo;
    // acc_hi/acc_lo: product {hi,lo} for multiply, {remainder,quotient} for divide
    logic [DATA_W-1:0]   acc_hi, acc_lo, operand_b_mag;
    logic                is_div, neg_q, neg_r, div_zero;

    logic [DATA_W-1:0]   op_b, alu_result;
    logic                is_md, signed_md, sign_a, sign_b, load;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] product, product_fixed;

    assign op_b      = in_alu_src ? in_sign_ext_imm : in_read_data_2;
    assign is_md     = (in_alu_op >= 4'd10) && (in_alu_op <= 4'd13);
    assign signed_md = (in_alu_op == 4'd10) || (in_alu_op == 4'd12);
    assign sign_a    = signed_md & in_read_data_1[DATA_W-1];
    assign sign_b    = signed_md & op_b[DATA_W-1];
    assign mag_a     = sign_a ? (~in_read_data_1 + 1'b1) : in_read_data_1;
    assign mag_b     = sign_b ? (~op_b + 1'b1) : op_b;

    assign stall = (state == BUSY) || ((state == IDLE) && in_valid && is_md);
    assign load  = !in_flush && (state == IDLE) && in_valid && !is_md;

    always_comb begin
        alu_result = '0;
        case (in_alu_op)
            4'd0:  alu_result = in_read_data_1 & op_b;
            4'd1:  alu_result = in_read_data_1 | op_b;
            4'd2:  alu_result = in_read_data_1 + op_b;
            4'd3:  alu_result = in_read_data_1 - op_b;
            4'd4:  alu_result = {{(DATA_W-1){1'b0}}, $signed(in_read_data_1) < $signed(op_b)};
            4'd5:  alu_result = ~(in_read_data_1 | op_b);
            4'd6:  alu_result = op_b << in_shamt;
            4'd7:  alu_result = op_b >> in_shamt;
            4'd8:  alu_result = DATA_W'($signed(op_b) >>> in_shamt);
            4'd9:  alu_result = {{(DATA_W-1){1'b0}}, in_read_data_1 < op_b};
            4'd14: alu_result = hi;
            4'd15: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b_mag} : '0);

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always fits, which
    // naturally yields an all-ones quotient and remainder = dividend.
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, operand_b_mag};
    assign div_diff  = div_shift - {1'b0, operand_b_mag};

    assign product       = {acc_hi, acc_lo};
    assign product_fixed = neg_q ? (~product + 1'b1) : product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            hi            <= '0;
            lo            <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            operand_b_mag <= '0;
            is_div        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_zero      <= 1'b0;
        end else if (in_flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && is_md) begin
                        state         <= BUSY;
                        count         <= '0;
                        acc_hi        <= '0;
                        acc_lo        <= mag_a;
                        operand_b_mag <= mag_b;
                        is_div        <= in_alu_op[2];
                        neg_q         <= sign_a ^ sign_b;
                        neg_r         <= sign_a;
                        div_zero      <= (op_b == '0);
                    end
                end
                BUSY: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(DATA_W-1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (is_div) begin
                        // Remainder follows the dividend's sign, so with a zero
                        // divisor HI restores the original dividend.
                        lo <= div_zero ? '1 : (neg_q ? (~acc_lo + 1'b1) : acc_lo);
                        hi <= neg_r ? (~acc_hi + 1'b1) : acc_hi;
                    end else begin
                        {hi, lo} <= product_fixed;
                    end
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // EX/MEM register: control bits clear on a bubble, data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_address    <= '0;
            out_write_data <= '0;
            out_zero       <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_write_back <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_branch     <= 1'b0;
            out_load_mode  <= '0;
            out_dest_reg   <= '0;
            out_valid      <= 1'b0;
        end else begin
            out_valid      <= load;
            out_mem_read   <= load & in_mem_read;
            out_mem_write  <= load & in_mem_write;
            out_write_back <= load & in_write_back;
            out_mem_to_reg <= load & in_mem_to_reg;
            out_branch     <= load & in_branch;
            out_load_mode  <= load ? in_load_mode : '0;
            out_dest_reg   <= load ? in_dest_reg : '0;
            if (load) begin
                out_address    <= alu_result;
                out_write_data <= in_read_data_2;
                out_zero       <= (alu_result == '0);
            end
        end
    end

endmodule
